// File: rtl/uut_result_capture.sv
// rtl/uut_result_capture.sv - times one PRESENT UUT run and serves the result record byte by byte
module uut_result_capture #(
    parameter int          RECORD_BYTES   = 32,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_uut,
    input  logic [63:0] block_o_uut,
    input  logic        end_key_signal_uut,
    input  logic        end_enc_uut,
    input  logic        end_dec_uut,
    input  logic        rd_req,
    output logic        rec_ready,
    output logic [7:0]  byte_o,
    output logic        byte_valid,
    output logic        busy,
    output logic        timeout
);

    localparam int IDX_W = $clog2(RECORD_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_BYTES - 1);
    // Fields occupy bytes 0..16; everything beyond reads as zero padding
    localparam logic [IDX_W-1:0] PAD_IDX  = IDX_W'(17);
    localparam logic [31:0]      ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, RUN, READY} state_t;

    state_t           state;
    state_t           state_next;
    logic             rst_uut_q;
    logic             fall;
    logic             end_any;
    logic             at_limit;
    logic             last_read;
    logic             key_seen;
    logic [31:0]      cnt;
    logic [31:0]      key_cyc;
    logic [31:0]      done_cyc;
    logic [63:0]      blk;
    logic [IDX_W-1:0] idx;
    logic [135:0]     rec_bits;
    logic [135:0]     rec_shift;
    logic [7:0]       rec_byte;

    assign fall      = rst_uut_q & ~rst_uut;
    assign end_any   = end_enc_uut | end_dec_uut;
    assign at_limit  = (cnt == TIMEOUT_CYCLES - 32'd1);
    assign last_read = rd_req && (idx == LAST_IDX);
    assign rec_ready = (state == READY);
    assign busy      = (state == RUN);

    // Select the record byte at idx; fields are packed MSB first starting at byte 0
    always_comb begin
        rec_bits  = {6'b0, timeout, key_seen, blk, key_cyc, done_cyc};
        rec_shift = rec_bits << {idx, 3'b000};
        rec_byte  = (idx < PAD_IDX) ? rec_shift[135:128] : 8'h00;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: a UUT reset aborts a run ahead of completion, completion ahead of timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fall) state_next = RUN;
            RUN: begin
                if (rst_uut)       state_next = IDLE;
                else if (end_any)  state_next = READY;
                else if (at_limit) state_next = READY;
            end
            READY:   if (last_read) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Run timing, result capture and the one-cycle-latency byte read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_uut_q  <= 1'b0;
            cnt        <= '0;
            key_seen   <= 1'b0;
            key_cyc    <= '0;
            done_cyc   <= '0;
            blk        <= '0;
            timeout    <= 1'b0;
            idx        <= '0;
            byte_o     <= '0;
            byte_valid <= 1'b0;
        end else begin
            rst_uut_q  <= rst_uut;
            byte_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        cnt      <= '0;
                        key_seen <= 1'b0;
                        key_cyc  <= ALL_ONES;
                        timeout  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!rst_uut) begin
                        if (cnt != ALL_ONES) cnt <= cnt + 32'd1;
                        if (end_key_signal_uut && !key_seen) begin
                            key_cyc  <= cnt;
                            key_seen <= 1'b1;
                        end
                        if (end_any) begin
                            done_cyc <= cnt;
                            blk      <= block_o_uut;
                            timeout  <= 1'b0;
                        end else if (at_limit) begin
                            done_cyc <= ALL_ONES;
                            blk      <= '0;
                            timeout  <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (rd_req) begin
                        byte_o     <= rec_byte;
                        byte_valid <= 1'b1;
                        idx        <= last_read ? '0 : idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uut_result_capture.sv
// tb/tb_uut_result_capture.sv - scoreboard bench for uut_result_capture with randomized runs
module tb_uut_result_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_uut;
    logic [63:0] block_o;
    logic        end_key;
    logic        end_enc;
    logic        end_dec;
    logic        rd_req;
    logic        rec_ready;
    logic [7:0]  byte_o;
    logic        byte_valid;
    logic        busy;
    logic        timeout;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];

    uut_result_capture #(
        .RECORD_BYTES  (32),
        .TIMEOUT_CYCLES(32'd16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rst_uut           (rst_uut),
        .block_o_uut       (block_o),
        .end_key_signal_uut(end_key),
        .end_enc_uut       (end_enc),
        .end_dec_uut       (end_dec),
        .rd_req            (rd_req),
        .rec_ready         (rec_ready),
        .byte_o            (byte_o),
        .byte_valid        (byte_valid),
        .busy              (busy),
        .timeout           (timeout)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every strobe must match the oldest outstanding expected byte
    always @(negedge clk) begin
        if (byte_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("byte_o", {56'd0, byte_o}, {56'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kk/ke: cycles after the fall at which end_key / end fire (kk=0 none, ke>16 never)
    // abort_at>0: a first run is killed by rst_uut at that offset
    // mode: 0 random-gap reads, 1 rd_req held 40 cycles, 2 rst after 5 reads
    task automatic run_case(input int kk, input int ke, input bit use_dec,
                            input logic [63:0] blk, input int abort_at, input int mode);
        logic [7:0]  rec[32];
        logic [31:0] kc;
        logic [31:0] dc;
        logic [63:0] eb;
        bit          to;
        bit          ks;
        int          last;
        int          m;
        int          budget;

        rst_uut = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'($urandom_range(0, 1));
            tick();
        end
        rd_req = 1'b0;

        if (abort_at > 0) begin
            rst_uut = 1'b0;
            tick();
            for (int j = 1; j < abort_at; j++) tick();
            rst_uut = 1'b1;
            end_enc = 1'b1;
            block_o = {$urandom, $urandom};
            tick();
            end_enc = 1'b0;
            check("abort_busy", {63'd0, busy}, 64'd0);
            check("abort_ready", {63'd0, rec_ready}, 64'd0);
            tick();
        end

        rst_uut = 1'b0;
        tick();
        check("run_busy", {63'd0, busy}, 64'd1);
        check("run_timeout_clr", {63'd0, timeout}, 64'd0);

        last = (ke < 16) ? ke : 16;
        for (int j = 1; j <= 16; j++) begin
            end_key = (j == kk) || (kk != 0 && j > kk && $urandom_range(0, 3) == 0);
            end_enc = (j == ke) && !use_dec;
            end_dec = (j == ke) && use_dec;
            block_o = (j == ke) ? blk : {$urandom, $urandom};
            tick();
            if (j == last) break;
        end
        end_key = 1'b0;
        end_enc = 1'b0;
        end_dec = 1'b0;
        rst_uut = 1'b1;
        tick();

        to = (ke > 16);
        ks = (kk != 0) && (kk <= last);
        kc = ks ? 32'(kk - 1) : 32'hFFFF_FFFF;
        dc = to ? 32'hFFFF_FFFF : 32'(ke - 1);
        eb = to ? 64'd0 : blk;
        rec[0] = {6'b0, to, ks};
        for (int i = 0; i < 8; i++) rec[1 + i] = eb[63 - 8 * i -: 8];
        for (int i = 0; i < 4; i++) rec[9 + i] = kc[31 - 8 * i -: 8];
        for (int i = 0; i < 4; i++) rec[13 + i] = dc[31 - 8 * i -: 8];
        for (int i = 17; i < 32; i++) rec[i] = 8'h00;

        check("ready", {63'd0, rec_ready}, 64'd1);
        check("ready_busy", {63'd0, busy}, 64'd0);
        check("timeout_flag", {63'd0, timeout}, {63'd0, to});

        rst_uut = 1'b0;
        tick();
        rst_uut = 1'b1;
        tick();
        check("fall_in_ready", {62'd0, rec_ready, busy}, 64'd2);

        m = 0;
        if (mode == 1) begin
            for (int c = 0; c < 40; c++) begin
                rd_req = 1'b1;
                check("held_ready", {63'd0, rec_ready}, {63'd0, m < 32});
                if (m < 32) begin
                    exp_q.push_back(rec[m]);
                    m++;
                end
                tick();
            end
        end else if (mode == 2) begin
            for (int c = 0; c < 5; c++) begin
                rd_req = 1'b1;
                exp_q.push_back(rec[m]);
                m++;
                tick();
            end
            rd_req = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("rst_byte_o", {56'd0, byte_o}, 64'd0);
            check("rst_outs", {60'd0, byte_valid, rec_ready, busy, timeout}, 64'd0);
            check("rst_drain", 64'(exp_q.size()), 64'd0);
            return;
        end else begin
            budget = 0;
            while (m < 32 && budget < 400) begin
                rd_req = ($urandom_range(0, 2) != 0);
                check("gap_ready", {63'd0, rec_ready}, 64'd1);
                if (rd_req) begin
                    exp_q.push_back(rec[m]);
                    m++;
                end
                tick();
                budget++;
            end
            if (m < 32) check("read_budget", 64'(m), 64'd32);
        end
        rd_req = 1'b0;
        tick();
        check("drained_ready", {62'd0, rec_ready, busy}, 64'd0);
        tick();
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        rst_uut = 1'b1;
        block_o = '0;
        end_key = 1'b0;
        end_enc = 1'b0;
        end_dec = 1'b0;
        rd_req  = 1'b0;
        repeat (3) tick();
        check("reset_byte_o", {56'd0, byte_o}, 64'd0);
        check("reset_outs", {60'd0, byte_valid, rec_ready, busy, timeout}, 64'd0);
        rst = 1'b0;

        run_case(3, 10, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 0);
        run_case(0, 99, 1'b0, {$urandom, $urandom}, 0, 0);
        run_case(0, 5, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 3, 0);
        run_case(7, 7, 1'b1, {$urandom, $urandom}, 0, 0);
        run_case(2, 16, 1'b0, {$urandom, $urandom}, 0, 1);
        run_case(4, 9, 1'b0, {$urandom, $urandom}, 0, 2);
        run_case(1, 1, 1'b0, {$urandom, $urandom}, 0, 0);

        for (int r = 0; r < 25; r++) begin
            run_case($urandom_range(0, 18), $urandom_range(1, 20), 1'($urandom_range(0, 1)),
                     {$urandom, $urandom},
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0,
                     $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
